uart_prog_loader: RTL
=====================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868; clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL provide parameter MAX_WORDS, default 256; largest program length accepted, in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous UART serial line, idle high.
REQ-006 SHALL have port imem_we, output, 1, instruction-memory write strobe, one cycle per word.
REQ-007 SHALL have port imem_addr, output, 32, byte address of the word being written.
REQ-008 SHALL have port imem_wdata, output, 32, instruction word being written.
REQ-009 SHALL have port run, output, 1, high once the whole program is loaded; releases the CPU.
REQ-010 SHALL have port busy, output, 1, high while a load is in progress after the first byte.
REQ-011 SHALL have port err, output, 1, sticky error flag.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-013 SHALL implement receiver FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-014 RX_IDLE: a synchronized rx of 0 SHALL enter RX_START and clear the bit-timer.
REQ-015 RX_START: after CLKS_PER_BIT/2 cycles, SHALL resample rx; 0 -> RX_DATA; 1 -> false start, back to RX_IDLE with no byte produced.
REQ-016 RX_DATA: SHALL sample 8 bits, one every CLKS_PER_BIT cycles, LSB first, then enter RX_STOP.
REQ-017 RX_STOP: after CLKS_PER_BIT cycles, SHALL sample rx; 1 -> one-cycle internal byte_valid pulse; 0 -> framing error; both -> RX_IDLE.
REQ-018 SHALL implement loader FSM states L_HDR_HI, L_HDR_LO, L_WORD, L_DONE, L_ERR.
REQ-019 Frame format SHALL be: 16-bit word count N, big-endian, then N words of 4 bytes each, MSB first.
REQ-020 L_HDR_HI: on a byte, SHALL latch N[15:8] -> L_HDR_LO.
REQ-021 L_HDR_LO: on a byte, SHALL latch N[7:0]. N==0 -> L_DONE; N>MAX_WORDS -> L_ERR; otherwise -> L_WORD with word_idx=0, byte_cnt=0.
REQ-022 L_WORD: SHALL shift each byte into the word register; on the 4th byte, imem_we=1 for exactly the next cycle.
REQ-023 During that imem_we cycle, imem_addr SHALL equal word_idx<<2 and imem_wdata SHALL hold the assembled word.
REQ-024 After each write, SHALL increment word_idx; if word_idx reaches N -> L_DONE, otherwise stay in L_WORD with byte_cnt=0.
REQ-025 imem_addr and imem_wdata SHALL hold their last values while imem_we=0.
REQ-026 L_DONE: run=1 and held; further rx bytes SHALL be ignored; exit only by reset.
REQ-027 A framing error in any loader state other than L_DONE SHALL force L_ERR.
REQ-028 L_ERR: err=1, run=0, imem_we=0; exit only by reset.
REQ-029 busy SHALL be 1 in L_HDR_LO and L_WORD, and 0 in all other states.
REQ-030 The bit timer SHALL be wide enough for CLKS_PER_BIT-1 with no wrap; word_idx SHALL be 16 bits.

Reset
REQ-031 While reset=0, SHALL asynchronously set: synchronizer flops=1, RX_IDLE, L_HDR_HI, imem_we=0, imem_addr=0, imem_wdata=0, run=0, busy=0, err=0, N=0, word_idx=0, byte_cnt=0.
REQ-032 Reset asserted mid-byte or mid-load SHALL discard the partial byte and word; after release, loading SHALL restart from the header.

Verification
REQ-033 Basic load: CLKS_PER_BIT=16, send 00 02 | 20 08 00 05 | AC 08 00 00 -> two imem_we pulses: (addr 0x0, data 0x20080005) then (0x4, 0xAC080000); run=1 one cycle after the second pulse; busy then 0.
REQ-034 Empty program: send 00 00 -> run=1 after the second byte's stop sample; no imem_we pulses.
REQ-035 Oversize: MAX_WORDS=4, send 00 05 -> err=1, run=0, no writes, subsequent bytes ignored.
REQ-036 Framing error: second word byte sent with stop bit 0 -> err=1, busy=0; no write for the partial word.
REQ-037 Glitch: rx low for 3 cycles (below CLKS_PER_BIT/2) -> no byte produced; the next valid header is still accepted.
REQ-038 Reset mid-load: assert reset during word 1 of a 3-word load, release, send a fresh 1-word frame -> single write at addr 0x0 with the new data; run=1.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a length-prefixed program over 8N1 serial and writes
// it word by word into instruction memory, then releases the CPU via run.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        run,
    output logic        busy,
    output logic        err
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF_CNT = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CNT);
    localparam logic [31:0]   MAX_W     = 32'(MAX_WORDS);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] L_HDR_HI = 3'd0;
    localparam logic [2:0] L_HDR_LO = 3'd1;
    localparam logic [2:0] L_WORD   = 3'd2;
    localparam logic [2:0] L_DONE   = 3'd3;
    localparam logic [2:0] L_ERR    = 3'd4;

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic [1:0]    rx_state_r;
    logic [TW-1:0] bit_timer_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    rx_shift_r;
    logic          byte_valid_r;
    logic          frame_err_r;

    logic [2:0]    l_state_r;
    logic [15:0]   n_r;
    logic [15:0]   word_idx_r;
    logic [1:0]    byte_cnt_r;
    logic [23:0]   word_r;
    logic          imem_we_r;
    logic [31:0]   imem_addr_r;
    logic [31:0]   imem_wdata_r;
    logic          run_r;
    logic          busy_r;
    logic          err_r;

    logic [2:0]    l_nxt_s;
    logic [15:0]   n_nxt_s;
    logic [15:0]   n_new_s;
    logic [15:0]   idx_nxt_s;
    logic [15:0]   idx_inc_s;
    logic [1:0]    cnt_nxt_s;
    logic [23:0]   word_nxt_s;
    logic          we_nxt_s;
    logic [31:0]   addr_nxt_s;
    logic [31:0]   wdata_nxt_s;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // 8N1 receiver: mid-bit sampling, emits one-cycle byte_valid / frame_err pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r   <= RX_IDLE;
            bit_timer_r  <= '0;
            bit_cnt_r    <= 3'd0;
            rx_shift_r   <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    bit_timer_r <= '0;
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_timer_r == HALF_LAST) begin
                        bit_timer_r <= '0;
                        bit_cnt_r   <= 3'd0;
                        rx_state_r  <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_timer_r <= bit_timer_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_timer_r == BIT_LAST) begin
                        bit_timer_r <= '0;
                        rx_shift_r  <= {rx_sync_r, rx_shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        bit_timer_r <= bit_timer_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_timer_r == BIT_LAST) begin
                        bit_timer_r  <= '0;
                        byte_valid_r <= rx_sync_r;
                        frame_err_r  <= ~rx_sync_r;
                        rx_state_r   <= RX_IDLE;
                    end else begin
                        bit_timer_r <= bit_timer_r + 1'b1;
                    end
                end
                default: begin
                    bit_timer_r <= '0;
                    rx_state_r  <= RX_IDLE;
                end
            endcase
        end
    end

    assign n_new_s   = {n_r[15:8], rx_shift_r};
    assign idx_inc_s = word_idx_r + 16'd1;

    // Loader next-state: header parse, word assembly, write strobe and completion.
    // The write strobe cycle is also the cycle in which word_idx advances.
    always_comb begin
        l_nxt_s     = l_state_r;
        n_nxt_s     = n_r;
        idx_nxt_s   = word_idx_r;
        cnt_nxt_s   = byte_cnt_r;
        word_nxt_s  = word_r;
        we_nxt_s    = 1'b0;
        addr_nxt_s  = imem_addr_r;
        wdata_nxt_s = imem_wdata_r;
        case (l_state_r)
            L_HDR_HI: begin
                if (frame_err_r) begin
                    l_nxt_s = L_ERR;
                end else if (byte_valid_r) begin
                    n_nxt_s = {rx_shift_r, n_r[7:0]};
                    l_nxt_s = L_HDR_LO;
                end else begin
                    l_nxt_s = L_HDR_HI;
                end
            end
            L_HDR_LO: begin
                if (frame_err_r) begin
                    l_nxt_s = L_ERR;
                end else if (byte_valid_r) begin
                    n_nxt_s = n_new_s;
                    if (n_new_s == 16'd0) begin
                        l_nxt_s = L_DONE;
                    end else if ({16'd0, n_new_s} > MAX_W) begin
                        l_nxt_s = L_ERR;
                    end else begin
                        l_nxt_s   = L_WORD;
                        idx_nxt_s = 16'd0;
                        cnt_nxt_s = 2'd0;
                    end
                end else begin
                    l_nxt_s = L_HDR_LO;
                end
            end
            L_WORD: begin
                if (frame_err_r) begin
                    l_nxt_s = L_ERR;
                end else if (imem_we_r) begin
                    idx_nxt_s = idx_inc_s;
                    cnt_nxt_s = 2'd0;
                    l_nxt_s   = (idx_inc_s == n_r) ? L_DONE : L_WORD;
                end else if (byte_valid_r) begin
                    word_nxt_s = {word_r[15:0], rx_shift_r};
                    if (byte_cnt_r == 2'd3) begin
                        we_nxt_s    = 1'b1;
                        addr_nxt_s  = {14'd0, word_idx_r, 2'b00};
                        wdata_nxt_s = {word_r, rx_shift_r};
                        cnt_nxt_s   = 2'd0;
                    end else begin
                        cnt_nxt_s = byte_cnt_r + 2'd1;
                    end
                end else begin
                    l_nxt_s = L_WORD;
                end
            end
            L_DONE: begin
                l_nxt_s = L_DONE;
            end
            L_ERR: begin
                l_nxt_s = L_ERR;
            end
            default: begin
                l_nxt_s = L_ERR;
            end
        endcase
    end

    // Loader state and registered outputs; status flags follow the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_state_r    <= L_HDR_HI;
            n_r          <= 16'd0;
            word_idx_r   <= 16'd0;
            byte_cnt_r   <= 2'd0;
            word_r       <= 24'd0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'd0;
            imem_wdata_r <= 32'd0;
            run_r        <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            l_state_r    <= l_nxt_s;
            n_r          <= n_nxt_s;
            word_idx_r   <= idx_nxt_s;
            byte_cnt_r   <= cnt_nxt_s;
            word_r       <= word_nxt_s;
            imem_we_r    <= we_nxt_s;
            imem_addr_r  <= addr_nxt_s;
            imem_wdata_r <= wdata_nxt_s;
            run_r        <= (l_nxt_s == L_DONE);
            busy_r       <= (l_nxt_s == L_HDR_LO) || (l_nxt_s == L_WORD);
            err_r        <= (l_nxt_s == L_ERR);
        end
    end

    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign run        = run_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule
